mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default params_pkg::ADDR_WIDTH, memory address width.
REQ-002 Parameter LINE_WIDTH, default 128, memory transfer width in bits.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive data grants tolerated while fetch waits.
REQ-004 Port clk_i  input  1  single clock; all state on rising edge.
REQ-005 Port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 Port if_req_i / if_addr_i  input  1 / ADDR_WIDTH  fetch read request and address, held until grant.
REQ-007 Port if_gnt_o / if_rsp_valid_o / if_rsp_data_o  output  1 / 1 / LINE_WIDTH  fetch grant, response strobe, read data.
REQ-008 Port dc_req_i / dc_wr_i / dc_addr_i / dc_wdata_i  input  1 / 1 / ADDR_WIDTH / LINE_WIDTH  data request, write flag, address, write data, held until grant.
REQ-009 Port dc_gnt_o / dc_rsp_valid_o / dc_rsp_data_o  output  1 / 1 / LINE_WIDTH  data grant, response strobe, read data.
REQ-010 Port mem_req_o / mem_wr_o / mem_addr_o / mem_wdata_o  output  1 / 1 / ADDR_WIDTH / LINE_WIDTH  memory request bundle.
REQ-011 Port mem_ack_i / mem_rdata_i  input  1 / LINE_WIDTH  memory completion strobe, read data valid with ack.

Function
REQ-012 FSM states: IDLE, BUSY_IF, BUSY_DC; exactly one transaction outstanding.
REQ-013 In IDLE, grant is combinational: at most one of if_gnt_o/dc_gnt_o high, only in IDLE, only for an asserted request.
REQ-014 Priority: data wins over fetch, unless starve_cnt == STARVE_LIMIT, then fetch wins.
REQ-015 starve_cnt increments (saturating at STARVE_LIMIT) on each data grant with if_req_i high; clears to 0 on fetch grant.
REQ-016 On grant in cycle N: address/write data/wr flag latched, state -> BUSY_owner at N+1, mem_req_o high from N+1.
REQ-017 mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o stay stable while BUSY until mem_ack_i sampled high.
REQ-018 mem_ack_i in cycle M (BUSY): owner rsp_valid pulses exactly one cycle at M+1, rsp_data = mem_rdata_i registered; state IDLE at M+1.
REQ-019 New grant permitted in cycle M+1 (same cycle as response); min request-to-request spacing 2 cycles plus memory latency.
REQ-020 Fetch requests are always reads (mem_wr_o=0); data writes also produce dc_rsp_valid_o with dc_rsp_data_o = 0.
REQ-021 mem_ack_i in IDLE is ignored; no response generated.
REQ-022 Simultaneous if_req_i and dc_req_i with starve_cnt < STARVE_LIMIT: dc granted, fetch waits.

Reset
REQ-023 rst_ni low: state IDLE, starve_cnt 0, all outputs 0 (gnt, rsp_valid, rsp_data, mem_* ), asynchronously.
REQ-024 Reset mid-transaction discards it; no response issued; later mem_ack_i in IDLE ignored per REQ-021.

Configuration
REQ-025 Macro ARB_PERF_CNT_EN defined: outputs if_gnt_cnt_o, dc_gnt_cnt_o, busy_cyc_cnt_o (32 bit, wrap-around, reset 0) count fetch grants, data grants, cycles in BUSY_*.
REQ-026 Macro undefined: these ports and counters absent; all other behaviour identical.

Structure
REQ-027 arb_state_t enum (IDLE, BUSY_IF, BUSY_DC) and LINE_WIDTH constant reside in params_pkg.
REQ-028 Perf counters in sub-module arb_perf_counters, instantiated only under ARB_PERF_CNT_EN.

Verification
REQ-029 dc read addr 0x40 alone, ack 3 cycles after mem_req_o -> dc_gnt_o cycle 0, mem_req_o cycles 1-3, dc_rsp_valid_o cycle 4 with ack data.
REQ-030 if_req_i and dc_req_i held continuously, STARVE_LIMIT=4 -> grant order DC,DC,DC,DC,IF,DC..., no fetch wait over 4 data grants.
REQ-031 dc write 0x80 data 0xDEADBEEF -> mem_wr_o=1, mem_wdata_o stable until ack, dc_rsp_valid_o one cycle with data 0.
REQ-032 rst_ni low during BUSY_IF -> all outputs 0 immediately; late ack after release -> no if_rsp_valid_o.
REQ-033 Requests held high at response cycle -> next grant same cycle as rsp_valid; mem_req_o low exactly one cycle between transactions.
REQ-034 ARB_PERF_CNT_EN, 3 IF + 2 DC transactions, 2-cycle ack -> if_gnt_cnt_o=3, dc_gnt_cnt_o=2, busy_cyc_cnt_o=10.

Source files
------------

// File: rtl/params_pkg.sv
// Shared constants and the arbiter state encoding for the memory arbiter slice.
package params_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int LINE_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_perf_counters.sv
// Grant and busy-cycle counters for mem_arbiter; built only with ARB_PERF_CNT_EN.
`ifdef ARB_PERF_CNT_EN
module arb_perf_counters (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_gnt,
    input  logic        dc_gnt,
    input  logic        busy,
    output logic [31:0] if_gnt_cnt,
    output logic [31:0] dc_gnt_cnt,
    output logic [31:0] busy_cyc_cnt
);

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            if_gnt_cnt   <= '0;
            dc_gnt_cnt   <= '0;
            busy_cyc_cnt <= '0;
        end else begin
            if (if_gnt) if_gnt_cnt <= if_gnt_cnt + 32'd1;
            if (dc_gnt) dc_gnt_cnt <= dc_gnt_cnt + 32'd1;
            if (busy)   busy_cyc_cnt <= busy_cyc_cnt + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding memory port.
// Optional perf counters under macro ARB_PERF_CNT_EN.
//
// state   | meaning
// IDLE    | no transaction outstanding; grant decided combinationally
// BUSY_IF | fetch read in flight, waiting for mem_ack_i
// BUSY_DC | data read/write in flight, waiting for mem_ack_i
module mem_arbiter #(
    parameter int ADDR_WIDTH   = params_pkg::ADDR_WIDTH,
    parameter int LINE_WIDTH   = params_pkg::LINE_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rsp_valid_o,
    output logic [LINE_WIDTH-1:0] if_rsp_data_o,
    input  logic                  dc_req_i,
    input  logic                  dc_wr_i,
    input  logic [ADDR_WIDTH-1:0] dc_addr_i,
    input  logic [LINE_WIDTH-1:0] dc_wdata_i,
    output logic                  dc_gnt_o,
    output logic                  dc_rsp_valid_o,
    output logic [LINE_WIDTH-1:0] dc_rsp_data_o,
    output logic                  mem_req_o,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [LINE_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [LINE_WIDTH-1:0] mem_rdata_i
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           if_gnt_cnt_o,
    output logic [31:0]           dc_gnt_cnt_o,
    output logic [31:0]           busy_cyc_cnt_o
`endif
);

    import params_pkg::*;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Grants are gated by rst_ni so they drop asynchronously with the rest of the outputs.
    always_comb begin
        if_gnt_o = 1'b0;
        dc_gnt_o = 1'b0;
        if (rst_ni && state == IDLE) begin
            if (if_req_i && (starved || !dc_req_i)) begin
                if_gnt_o = 1'b1;
            end else if (dc_req_i) begin
                dc_gnt_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            starve_cnt     <= '0;
            mem_req_o      <= 1'b0;
            mem_wr_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            if_rsp_valid_o <= 1'b0;
            if_rsp_data_o  <= '0;
            dc_rsp_valid_o <= 1'b0;
            dc_rsp_data_o  <= '0;
        end else begin
            if_rsp_valid_o <= 1'b0;
            dc_rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_gnt_o) begin
                        state       <= BUSY_IF;
                        mem_req_o   <= 1'b1;
                        mem_wr_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                        starve_cnt  <= '0;
                    end else if (dc_gnt_o) begin
                        state       <= BUSY_DC;
                        mem_req_o   <= 1'b1;
                        mem_wr_o    <= dc_wr_i;
                        mem_addr_o  <= dc_addr_i;
                        mem_wdata_o <= dc_wdata_i;
                        if (if_req_i && !starved) starve_cnt <= starve_cnt + CNT_W'(1);
                    end
                end
                BUSY_IF: begin
                    if (mem_ack_i) begin
                        state          <= IDLE;
                        mem_req_o      <= 1'b0;
                        if_rsp_valid_o <= 1'b1;
                        if_rsp_data_o  <= mem_rdata_i;
                    end
                end
                BUSY_DC: begin
                    if (mem_ack_i) begin
                        state          <= IDLE;
                        mem_req_o      <= 1'b0;
                        dc_rsp_valid_o <= 1'b1;
                        // Writes complete with an all-zero response line.
                        dc_rsp_data_o  <= mem_wr_o ? '0 : mem_rdata_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    arb_perf_counters u_perf (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .if_gnt       (if_gnt_o),
        .dc_gnt       (dc_gnt_o),
        .busy         (state != IDLE),
        .if_gnt_cnt   (if_gnt_cnt_o),
        .dc_gnt_cnt   (dc_gnt_cnt_o),
        .busy_cyc_cnt (busy_cyc_cnt_o)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus hand sequences for starvation and reset.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          if_req_i, dc_req_i, dc_wr_i, mem_ack_i;
    logic [AW-1:0] if_addr_i, dc_addr_i;
    logic [LW-1:0] dc_wdata_i, mem_rdata_i;
    logic          if_gnt_o, if_rsp_valid_o, dc_gnt_o, dc_rsp_valid_o;
    logic [LW-1:0] if_rsp_data_o, dc_rsp_data_o, mem_wdata_o;
    logic          mem_req_o, mem_wr_o;
    logic [AW-1:0] mem_addr_o;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   if_gnt_cnt_o, dc_gnt_cnt_o, busy_cyc_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(4)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_gnt_o       (if_gnt_o),
        .if_rsp_valid_o (if_rsp_valid_o),
        .if_rsp_data_o  (if_rsp_data_o),
        .dc_req_i       (dc_req_i),
        .dc_wr_i        (dc_wr_i),
        .dc_addr_i      (dc_addr_i),
        .dc_wdata_i     (dc_wdata_i),
        .dc_gnt_o       (dc_gnt_o),
        .dc_rsp_valid_o (dc_rsp_valid_o),
        .dc_rsp_data_o  (dc_rsp_data_o),
        .mem_req_o      (mem_req_o),
        .mem_wr_o       (mem_wr_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rdata_i    (mem_rdata_i)
`ifdef ARB_PERF_CNT_EN
        ,
        .if_gnt_cnt_o   (if_gnt_cnt_o),
        .dc_gnt_cnt_o   (dc_gnt_cnt_o),
        .busy_cyc_cnt_o (busy_cyc_cnt_o)
`endif
    );

    typedef struct {
        logic        ifr, dcr, wr;
        logic [31:0] ia, da, wd;
        logic        ack;
        logic [31:0] rd;
        logic [1:0]  eg;     // {if_gnt, dc_gnt}
        logic        emr, emw;
        logic [31:0] ema, emwd;
        logic [1:0]  ers;    // {if_rsp_valid, dc_rsp_valid}
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic v(input logic ifr, input logic dcr, input logic wr,
                     input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                     input logic ack, input logic [31:0] rd,
                     input logic [1:0] eg, input logic emr, input logic emw,
                     input logic [31:0] ema, input logic [31:0] emwd,
                     input logic [1:0] ers, input logic [31:0] erd);
        vec_t t;
        t = '{ifr, dcr, wr, ia, da, wd, ack, rd, eg, emr, emw, ema, emwd, ers, erd};
        vecs.push_back(t);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_i    = 1'b0;
        dc_req_i    = 1'b0;
        dc_wr_i     = 1'b0;
        mem_ack_i   = 1'b0;
        if_addr_i   = '0;
        dc_addr_i   = '0;
        dc_wdata_i  = '0;
        mem_rdata_i = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_gnt"},   {127'd0, if_gnt_o}, 128'd0);
        check({tag, "_dc_gnt"},   {127'd0, dc_gnt_o}, 128'd0);
        check({tag, "_mem_req"},  {127'd0, mem_req_o}, 128'd0);
        check({tag, "_mem_wr"},   {127'd0, mem_wr_o}, 128'd0);
        check({tag, "_mem_addr"}, {96'd0, mem_addr_o}, 128'd0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 128'd0);
        check({tag, "_rsp_valid"}, {126'd0, if_rsp_valid_o, dc_rsp_valid_o}, 128'd0);
        check({tag, "_if_rsp_data"}, if_rsp_data_o, 128'd0);
        check({tag, "_dc_rsp_data"}, dc_rsp_data_o, 128'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        clear_inputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cycle();
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic perf_txn(input bit is_if);
        if_req_i  = is_if;
        dc_req_i  = !is_if;
        if_addr_i = 32'h500;
        dc_addr_i = 32'h600;
        next_cycle();
        if_req_i = 1'b0;
        dc_req_i = 1'b0;
        next_cycle();
        mem_ack_i = 1'b1;
        next_cycle();
        mem_ack_i = 1'b0;
    endtask
`endif

    initial begin
        logic [1:0] gorder [6];
        logic [1:0] gexp   [6];
        int         ng;
        vec_t       t;

        // cycle-accurate directed vectors; each entry is one clock
        v(0,1,0, 0,32'h40,0,          0,0,          2'b01, 0,0,0,0,                  2'b00,0);
        v(0,0,0, 0,0,0,               0,0,          2'b00, 1,0,32'h40,0,             2'b00,0);
        v(0,0,0, 0,0,0,               0,0,          2'b00, 1,0,32'h40,0,             2'b00,0);
        v(0,0,0, 0,0,0,               1,32'hA5A5,   2'b00, 1,0,32'h40,0,             2'b00,0);
        v(0,0,0, 0,0,0,               0,0,          2'b00, 0,0,0,0,                  2'b01,32'hA5A5);
        v(0,0,0, 0,0,0,               1,32'hBAD,    2'b00, 0,0,0,0,                  2'b00,0);
        v(0,0,0, 0,0,0,               0,0,          2'b00, 0,0,0,0,                  2'b00,0);
        v(0,1,1, 0,32'h80,32'hDEADBEEF, 0,0,        2'b01, 0,0,0,0,                  2'b00,0);
        v(0,0,0, 0,0,0,               0,0,          2'b00, 1,1,32'h80,32'hDEADBEEF,  2'b00,0);
        v(0,0,0, 0,0,0,               1,32'h1234,   2'b00, 1,1,32'h80,32'hDEADBEEF,  2'b00,0);
        v(0,0,0, 0,0,0,               0,0,          2'b00, 0,0,0,0,                  2'b01,0);
        v(0,0,0, 0,0,0,               0,0,          2'b00, 0,0,0,0,                  2'b00,0);
        v(1,0,0, 32'h100,0,0,         0,0,          2'b10, 0,0,0,0,                  2'b00,0);
        v(0,0,0, 0,0,0,               0,0,          2'b00, 1,0,32'h100,0,            2'b00,0);
        v(0,0,0, 0,0,0,               1,32'h77,     2'b00, 1,0,32'h100,0,            2'b00,0);
        v(0,0,0, 0,0,0,               0,0,          2'b00, 0,0,0,0,                  2'b10,32'h77);
        v(1,1,0, 32'h200,32'h300,0,   0,0,          2'b01, 0,0,0,0,                  2'b00,0);
        v(1,0,0, 32'h200,0,0,         1,32'h55,     2'b00, 1,0,32'h300,0,            2'b00,0);
        v(1,0,0, 32'h200,0,0,         0,0,          2'b10, 0,0,0,0,                  2'b01,32'h55);
        v(0,0,0, 0,0,0,               1,32'h66,     2'b00, 1,0,32'h200,0,            2'b00,0);
        v(0,0,0, 0,0,0,               0,0,          2'b00, 0,0,0,0,                  2'b10,32'h66);

        rst_ni = 1'b0;
        clear_inputs();
        if_req_i = 1'b1;
        dc_req_i = 1'b1;
        #12;
        check_all_zero("reset");
        clear_inputs();
        rst_ni = 1'b1;
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            if_req_i    = t.ifr;
            dc_req_i    = t.dcr;
            dc_wr_i     = t.wr;
            if_addr_i   = t.ia;
            dc_addr_i   = t.da;
            dc_wdata_i  = {96'd0, t.wd};
            mem_ack_i   = t.ack;
            mem_rdata_i = {96'd0, t.rd};
            #1;
            check($sformatf("v%0d_gnt", i), {126'd0, if_gnt_o, dc_gnt_o}, {126'd0, t.eg});
            check($sformatf("v%0d_mem_req", i), {127'd0, mem_req_o}, {127'd0, t.emr});
            if (t.emr) begin
                check($sformatf("v%0d_mem_wr", i), {127'd0, mem_wr_o}, {127'd0, t.emw});
                check($sformatf("v%0d_mem_addr", i), {96'd0, mem_addr_o}, {96'd0, t.ema});
                check($sformatf("v%0d_mem_wdata", i), mem_wdata_o, {96'd0, t.emwd});
            end
            check($sformatf("v%0d_rsp_valid", i), {126'd0, if_rsp_valid_o, dc_rsp_valid_o}, {126'd0, t.ers});
            if (t.ers[1]) check($sformatf("v%0d_if_rsp_data", i), if_rsp_data_o, {96'd0, t.erd});
            if (t.ers[0]) check($sformatf("v%0d_dc_rsp_data", i), dc_rsp_data_o, {96'd0, t.erd});
            next_cycle();
        end

        // starvation: both requesters held, single-cycle memory latency
        do_reset();
        gexp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        ng = 0;
        if_req_i  = 1'b1;
        dc_req_i  = 1'b1;
        if_addr_i = 32'h200;
        dc_addr_i = 32'h300;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            mem_ack_i = mem_req_o;
            #1;
            if (if_gnt_o || dc_gnt_o) begin
                if (ng > 0) begin
                    check($sformatf("starve_gap%0d_mem_req", ng), {127'd0, mem_req_o}, 128'd0);
                    check($sformatf("starve_gap%0d_rsp", ng), {127'd0, if_rsp_valid_o | dc_rsp_valid_o}, 128'd1);
                end
                gorder[ng] = {if_gnt_o, dc_gnt_o};
                ng++;
            end
            next_cycle();
        end
        check("starve_grant_count", 128'(ng), 128'd6);
        for (int g = 0; g < 6; g++) begin
            if (g < ng) check($sformatf("starve_order%0d", g), {126'd0, gorder[g]}, {126'd0, gexp[g]});
        end
        check("starve_post_grant_mem_req", {127'd0, mem_req_o}, 128'd1);
        if_req_i = 1'b0;
        dc_req_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_ack_i = mem_req_o;
            next_cycle();
        end
        mem_ack_i = 1'b0;

        // reset during BUSY_IF, then a stray late ack
        if_req_i  = 1'b1;
        if_addr_i = 32'h400;
        #1;
        check("rst_busy_if_gnt", {127'd0, if_gnt_o}, 128'd1);
        next_cycle();
        check("rst_busy_mem_req", {127'd0, mem_req_o}, 128'd1);
        check("rst_busy_mem_addr", {96'd0, mem_addr_o}, 128'h400);
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("rst_mid");
        if_req_i = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 128'hFEED;
        next_cycle();
        mem_ack_i = 1'b0;
        #1;
        check("late_ack_if_rsp", {127'd0, if_rsp_valid_o}, 128'd0);
        check("late_ack_mem_req", {127'd0, mem_req_o}, 128'd0);
        next_cycle();
        check("late_ack_if_rsp2", {127'd0, if_rsp_valid_o}, 128'd0);

`ifdef ARB_PERF_CNT_EN
        do_reset();
        check("perf_reset_if", {96'd0, if_gnt_cnt_o}, 128'd0);
        perf_txn(1'b1);
        perf_txn(1'b0);
        perf_txn(1'b1);
        perf_txn(1'b0);
        perf_txn(1'b1);
        next_cycle();
        check("perf_if_gnt_cnt", {96'd0, if_gnt_cnt_o}, 128'd3);
        check("perf_dc_gnt_cnt", {96'd0, dc_gnt_cnt_o}, 128'd2);
        check("perf_busy_cyc_cnt", {96'd0, busy_cyc_cnt_o}, 128'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
